// File: rtl/smbm_multi_sorted.sv
// Sorted multi-metric buffer manager: one id-sorted list plus NUM_METRICS value-sorted lists.
// Define SMBM_UPDATE_EN to enable op 3 (UPDATE); without it op 3 answers BAD_OP.
module smbm_multi_sorted #(
  parameter int NUM_ENTRIES = 128,
  parameter int NUM_METRICS = 8,
  parameter int METRIC_W    = 8,
  localparam int ID_W   = $clog2(NUM_ENTRIES),
  localparam int MSEL_W = (NUM_METRICS > 1) ? $clog2(NUM_METRICS) : 1,
  localparam int SLOT_W = ID_W + METRIC_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [1:0]                      req_op,
  input  logic [ID_W-1:0]                 req_id,
  input  logic [NUM_METRICS*METRIC_W-1:0] req_metrics,
  input  logic [MSEL_W-1:0]               req_msel,
  input  logic                            req_masked,
  input  logic [NUM_ENTRIES-1:0]          req_mask,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [2:0]                      rsp_status,
  output logic [NUM_ENTRIES*SLOT_W-1:0]   rsp_list,
  output logic [NUM_ENTRIES-1:0]          rsp_list_vld,
  output logic [ID_W:0]                   count
);
  localparam int CW = ID_W + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(NUM_ENTRIES);
  localparam logic [MSEL_W:0] MSEL_BOUND = (MSEL_W+1)'(NUM_METRICS);
  localparam logic [1:0] OP_ADD = 2'd0, OP_DEL = 2'd1, OP_READ = 2'd2, OP_UPD = 2'd3;
  localparam logic [2:0] ST_OK = 3'd0, ST_FULL = 3'd1, ST_NF = 3'd2, ST_DUP = 3'd3, ST_BAD = 3'd4;
`ifdef SMBM_UPDATE_EN
  localparam bit UPDATE_EN = 1'b1;
`else
  localparam bit UPDATE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CMP, UPD, RESP} state_t;
  state_t state, next_state;

  logic [ID_W-1:0]     id_list [NUM_ENTRIES];
  logic [METRIC_W-1:0] met_val [NUM_METRICS][NUM_ENTRIES];
  logic [ID_W-1:0]     met_id  [NUM_METRICS][NUM_ENTRIES];

  logic [1:0]                      op;
  logic [ID_W-1:0]                 id;
  logic [NUM_METRICS*METRIC_W-1:0] metrics;
  logic [MSEL_W-1:0]               msel;
  logic                            masked;
  logic [NUM_ENTRIES-1:0]          mask;
  logic                            second_pass;

  logic          hit, hit_c;
  logic [CW-1:0] id_pos, id_pos_c;
  logic [CW-1:0] met_pos [NUM_METRICS];
  logic [CW-1:0] met_pos_c [NUM_METRICS];

  logic       update_op, del_pass, add_pass, bad_msel, add_go, rem_go;
  logic [2:0] upd_status;

  // UPDATE is a delete pass followed by an add pass, tracked by second_pass.
  assign update_op = UPDATE_EN && (op == OP_UPD);
  assign del_pass  = (op == OP_DEL) || (update_op && !second_pass);
  assign add_pass  = (op == OP_ADD) || (update_op && second_pass);
  assign bad_msel  = {1'b0, msel} >= MSEL_BOUND;
  assign add_go    = add_pass && !hit && (count != FULL_COUNT);
  assign rem_go    = del_pass && hit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = CMP;
      end
      CMP:  next_state = UPD;
      UPD:  next_state = (update_op && !second_pass && hit) ? CMP : RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Descending scan so the lowest matching slot wins the priority encode.
  always_comb begin
    hit_c    = 1'b0;
    id_pos_c = del_pass ? '0 : count;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (CW'(i) < count) begin
        if (id_list[i] == id) hit_c = 1'b1;
        if (del_pass ? (id_list[i] == id) : (id_list[i] > id)) id_pos_c = CW'(i);
      end
    end
    for (int j = 0; j < NUM_METRICS; j++) begin
      met_pos_c[j] = del_pass ? '0 : count;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
        if (CW'(i) < count &&
            (del_pass ? (met_id[j][i] == id) : (met_val[j][i] > metrics[j*METRIC_W +: METRIC_W])))
          met_pos_c[j] = CW'(i);
      end
    end
  end

  always_comb begin
    upd_status = ST_BAD;
    if (op == OP_READ)  upd_status = bad_msel ? ST_BAD : ST_OK;
    else if (add_pass)  upd_status = hit ? ST_DUP : ((count == FULL_COUNT) ? ST_FULL : ST_OK);
    else if (del_pass)  upd_status = hit ? ST_OK : ST_NF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      rsp_status   <= '0;
      rsp_list     <= '0;
      rsp_list_vld <= '0;
      op           <= '0;
      id           <= '0;
      metrics      <= '0;
      msel         <= '0;
      masked       <= 1'b0;
      mask         <= '0;
      second_pass  <= 1'b0;
      hit          <= 1'b0;
      id_pos       <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) id_list[i] <= '0;
      for (int j = 0; j < NUM_METRICS; j++) begin
        met_pos[j] <= '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          met_val[j][i] <= '0;
          met_id[j][i]  <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op          <= req_op;
          id          <= req_id;
          metrics     <= req_metrics;
          msel        <= req_msel;
          masked      <= req_masked;
          mask        <= req_mask;
          second_pass <= 1'b0;
        end
        CMP: begin
          hit     <= hit_c;
          id_pos  <= id_pos_c;
          met_pos <= met_pos_c;
        end
        UPD: begin
          second_pass <= 1'b1;
          rsp_status  <= upd_status;
          // Slots above count are always zero, so shifting them is harmless.
          if (add_go) begin
            if (id_pos == '0) id_list[0] <= id;
            for (int i = 1; i < NUM_ENTRIES; i++) begin
              if (CW'(i) == id_pos)     id_list[i] <= id;
              else if (CW'(i) > id_pos) id_list[i] <= id_list[i-1];
            end
            for (int j = 0; j < NUM_METRICS; j++) begin
              if (met_pos[j] == '0) begin
                met_val[j][0] <= metrics[j*METRIC_W +: METRIC_W];
                met_id[j][0]  <= id;
              end
              for (int i = 1; i < NUM_ENTRIES; i++) begin
                if (CW'(i) == met_pos[j]) begin
                  met_val[j][i] <= metrics[j*METRIC_W +: METRIC_W];
                  met_id[j][i]  <= id;
                end else if (CW'(i) > met_pos[j]) begin
                  met_val[j][i] <= met_val[j][i-1];
                  met_id[j][i]  <= met_id[j][i-1];
                end
              end
            end
            count <= count + CW'(1);
          end
          if (rem_go) begin
            for (int i = 0; i < NUM_ENTRIES - 1; i++)
              if (CW'(i) >= id_pos) id_list[i] <= id_list[i+1];
            id_list[NUM_ENTRIES-1] <= '0;
            for (int j = 0; j < NUM_METRICS; j++) begin
              for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
                if (CW'(i) >= met_pos[j]) begin
                  met_val[j][i] <= met_val[j][i+1];
                  met_id[j][i]  <= met_id[j][i+1];
                end
              end
              met_val[j][NUM_ENTRIES-1] <= '0;
              met_id[j][NUM_ENTRIES-1]  <= '0;
            end
            count <= count - CW'(1);
          end
          if (op == OP_READ) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
              if (!bad_msel && CW'(i) < count) begin
                if (masked && !mask[met_id[msel][i]]) begin
                  rsp_list[i*SLOT_W +: SLOT_W] <= '1;
                  rsp_list_vld[i]              <= 1'b0;
                end else begin
                  rsp_list[i*SLOT_W +: SLOT_W] <= {met_id[msel][i], met_val[msel][i]};
                  rsp_list_vld[i]              <= 1'b1;
                end
              end else begin
                rsp_list[i*SLOT_W +: SLOT_W] <= '0;
                rsp_list_vld[i]              <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
